// File: rtl/serial_bit_tx_if.sv
// Word handshake into serial_bit_tx: producer is master, transmitter is slave.
interface serial_bit_tx_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/serial_bit_tx.sv
// Framed single-wire transmitter: start, data MSB-first, parity, stop.
// Even parity bit compiled in only with SERIAL_BIT_TX_PARITY_EN defined.
module serial_bit_tx #(
   parameter int DATA_W = 8,
   parameter int DIV    = 1
) (
   input  logic           clk,
   input  logic           rst,
   serial_bit_tx_if.slave tx,
   output logic           ser_out,
   output logic           ser_frame,
   output logic           busy
);
   localparam int DW = $clog2(DIV + 1);
   localparam int BW = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP
`ifdef SERIAL_BIT_TX_PARITY_EN
      , PARITY
`endif
   } state_t;

   state_t            state, state_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic [DW-1:0]     div_cnt, div_n;
   logic [BW-1:0]     bit_cnt, bit_n;
   logic              div_last, bit_last, hs;
   logic              so_n, sf_n;
`ifdef SERIAL_BIT_TX_PARITY_EN
   logic              par, par_n;
`endif

   assign tx.tx_ready = (state == IDLE);
   assign hs          = tx.tx_valid && tx.tx_ready;
   assign div_last    = (div_cnt == DW'(DIV - 1));
   assign bit_last    = (bit_cnt == BW'(DATA_W - 1));

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      div_n   = div_cnt;
      bit_n   = bit_cnt;
`ifdef SERIAL_BIT_TX_PARITY_EN
      par_n   = par;
`endif
      if (state != IDLE)
         div_n = div_last ? '0 : div_cnt + DW'(1);
      case (state)
         IDLE: begin
            if (hs) begin
               shreg_n = tx.tx_data;
               div_n   = '0;
               bit_n   = '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
               par_n   = ^tx.tx_data;
`endif
               state_n = START;
            end
         end
         START: begin
            if (div_last)
               state_n = DATA;
         end
         DATA: begin
            if (div_last) begin
               shreg_n = shreg << 1;
               bit_n   = bit_cnt + BW'(1);
               if (bit_last) begin
`ifdef SERIAL_BIT_TX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end
            end
         end
`ifdef SERIAL_BIT_TX_PARITY_EN
         PARITY: begin
            if (div_last)
               state_n = STOP;
         end
`endif
         STOP: begin
            if (div_last)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Line outputs are decoded from the next state so they register in step with it.
   always_comb begin
      so_n = 1'b1;
      sf_n = 1'b0;
      unique case (1'b1)
         (state_n == START): so_n = 1'b0;
         (state_n == DATA): begin
            so_n = shreg_n[DATA_W-1];
            sf_n = 1'b1;
         end
`ifdef SERIAL_BIT_TX_PARITY_EN
         (state_n == PARITY): begin
            so_n = par_n;
            sf_n = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= '0;
         div_cnt   <= '0;
         bit_cnt   <= '0;
`ifdef SERIAL_BIT_TX_PARITY_EN
         par       <= 1'b0;
`endif
         ser_out   <= 1'b1;
         ser_frame <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         div_cnt   <= div_n;
         bit_cnt   <= bit_n;
`ifdef SERIAL_BIT_TX_PARITY_EN
         par       <= par_n;
`endif
         ser_out   <= so_n;
         ser_frame <= sf_n;
         busy      <= (state_n != IDLE);
      end
   end
endmodule

// File: tb/tb_serial_bit_tx.sv
// Scoreboard bench for serial_bit_tx: three instances (8b/div1, 8b/div3, 1b/div1).
module tb_serial_bit_tx;
`ifdef SERIAL_BIT_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   serial_bit_tx_if #(.DATA_W(8)) if8 ();
   serial_bit_tx_if #(.DATA_W(8)) if3 ();
   serial_bit_tx_if #(.DATA_W(1)) if1 ();

   logic so8, sf8, b8, so3, sf3, b3, so1, sf1, b1;

   serial_bit_tx #(.DATA_W(8), .DIV(1)) u8 (
      .clk(clk), .rst(rst), .tx(if8.slave),
      .ser_out(so8), .ser_frame(sf8), .busy(b8));
   serial_bit_tx #(.DATA_W(8), .DIV(3)) u3 (
      .clk(clk), .rst(rst), .tx(if3.slave),
      .ser_out(so3), .ser_frame(sf3), .busy(b3));
   serial_bit_tx #(.DATA_W(1), .DIV(1)) u1 (
      .clk(clk), .rst(rst), .tx(if1.slave),
      .ser_out(so1), .ser_frame(sf1), .busy(b1));

   int n_chk  = 0;
   int n_fail = 0;

   // entries are {ser_out, ser_frame} per busy cycle
   logic [1:0] q8[$];
   logic [1:0] q3[$];
   logic [1:0] q1[$];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic qpush(input int s, input logic [1:0] e);
      case (s)
         0: q8.push_back(e);
         1: q3.push_back(e);
         default: q1.push_back(e);
      endcase
   endtask

   // hand-written bit strings, MSB first, DIV=1, first/last are start/stop
   task automatic push_bits(input int s, input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--)
         qpush(s, {bits[i], (i != n - 1) && (i != 0)});
   endtask

   task automatic push_frame(input int s, input logic [15:0] d,
                             input int w, input int dv);
      logic p;
      p = 1'b0;
      for (int k = 0; k < dv; k++) qpush(s, 2'b00);
      for (int i = w - 1; i >= 0; i--) begin
         p = p ^ d[i];
         for (int k = 0; k < dv; k++) qpush(s, {d[i], 1'b1});
      end
      if (P == 1)
         for (int k = 0; k < dv; k++) qpush(s, {p, 1'b1});
      for (int k = 0; k < dv; k++) qpush(s, 2'b10);
   endtask

   task automatic drive(input int s, input logic v, input logic [15:0] d);
      case (s)
         0: begin if8.tx_valid = v; if8.tx_data = d[7:0]; end
         1: begin if3.tx_valid = v; if3.tx_data = d[7:0]; end
         default: begin if1.tx_valid = v; if1.tx_data = d[0:0]; end
      endcase
   endtask

   task automatic get(input int s, output logic b, output logic f,
                      output logic r);
      case (s)
         0: begin b = b8; f = sf8; r = if8.tx_ready; end
         1: begin b = b3; f = sf3; r = if3.tx_ready; end
         default: begin b = b1; f = sf1; r = if1.tx_ready; end
      endcase
   endtask

   task automatic send(input int s, input logic [15:0] d,
                       output int nb, output int nf, output logic rdy);
      logic b, f;
      nb = 0;
      nf = 0;
      rdy = 1'b0;
      @(negedge clk);
      drive(s, 1'b1, d);
      @(posedge clk);
      #1 drive(s, 1'b0, d);
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         get(s, b, f, rdy);
         if (!b) break;
         nb++;
         if (f) nf++;
      end
   endtask

   logic [1:0] e8, e3, e1;

   always @(negedge clk) begin
      if (b8) begin
         if (q8.size() == 0) chk("u8 unexpected busy", 32'd1, 32'd0);
         else begin e8 = q8.pop_front(); chk("u8 stream", {so8, sf8}, e8); end
      end else chk("u8 idle line", {so8, sf8}, 32'h2);
   end

   always @(negedge clk) begin
      if (b3) begin
         if (q3.size() == 0) chk("u3 unexpected busy", 32'd1, 32'd0);
         else begin e3 = q3.pop_front(); chk("u3 stream", {so3, sf3}, e3); end
      end else chk("u3 idle line", {so3, sf3}, 32'h2);
   end

   always @(negedge clk) begin
      if (b1) begin
         if (q1.size() == 0) chk("u1 unexpected busy", 32'd1, 32'd0);
         else begin e1 = q1.pop_front(); chk("u1 stream", {so1, sf1}, e1); end
      end else chk("u1 idle line", {so1, sf1}, 32'h2);
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, nf, gap;
      logic rdy;
      drive(0, 1'b0, 16'h0);
      drive(1, 1'b0, 16'h0);
      drive(2, 1'b0, 16'h0);
      repeat (3) @(negedge clk);
      chk("rst u8 ser_out", so8, 1);
      chk("rst u8 ser_frame", sf8, 0);
      chk("rst u8 busy", b8, 0);
      chk("rst u8 tx_ready", if8.tx_ready, 1);
      chk("rst u3 ser_out", so3, 1);
      chk("rst u3 busy", b3, 0);
      chk("rst u3 tx_ready", if3.tx_ready, 1);
      chk("rst u1 ser_out", so1, 1);
      chk("rst u1 busy", b1, 0);
      chk("rst u1 tx_ready", if1.tx_ready, 1);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post-rst u8 tx_ready", if8.tx_ready, 1);

      // 0xA5: 0,1,0,1,0,0,1,0,1,[0],1
      if (P == 1) push_bits(0, 32'b01010010101, 11);
      else        push_bits(0, 32'b0101001011, 10);
      send(0, 16'hA5, nb, nf, rdy);
      chk("A5 busy cycles", nb, 10 + P);
      chk("A5 frame cycles", nf, 8 + P);
      chk("A5 ready after", rdy, 1);

      push_frame(0, 16'h07, 8, 1);
      send(0, 16'h07, nb, nf, rdy);
      chk("07 busy cycles", nb, 10 + P);

      push_frame(1, 16'h80, 8, 3);
      send(1, 16'h80, nb, nf, rdy);
      chk("div3 80 busy cycles", nb, 30 + 3 * P);
      chk("div3 80 frame cycles", nf, 24 + 3 * P);

      // back-to-back with tx_valid held and tx_data changing mid-frame
      push_frame(0, 16'h00, 8, 1);
      push_frame(0, 16'hFF, 8, 1);
      @(negedge clk);
      drive(0, 1'b1, 16'h00);
      @(posedge clk);
      #1 drive(0, 1'b1, 16'hFF);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!b8) break;
      end
      gap = 0;
      while (!b8 && gap < 50) begin
         gap++;
         @(negedge clk);
      end
      chk("b2b idle gap", gap, 1);
      drive(0, 1'b0, 16'h00);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!b8) break;
      end

      // reset during data bit 4 of 0x55 (ser_out low at that point)
      push_frame(0, 16'h55, 8, 1);
      @(negedge clk);
      drive(0, 1'b1, 16'h55);
      @(posedge clk);
      #1 drive(0, 1'b0, 16'h55);
      repeat (6) @(negedge clk);
      chk("pre-abort ser_out", so8, 0);
      #2 rst = 1'b1;
      #1;
      chk("abort ser_out", so8, 1);
      chk("abort busy", b8, 0);
      chk("abort ser_frame", sf8, 0);
      chk("abort tx_ready", if8.tx_ready, 1);
      q8.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      push_frame(0, 16'h3C, 8, 1);
      send(0, 16'h3C, nb, nf, rdy);
      chk("3C busy cycles", nb, 10 + P);

      // DATA_W=1: 0,1,[1],1
      if (P == 1) push_bits(2, 32'b0111, 4);
      else        push_bits(2, 32'b011, 3);
      send(2, 16'h1, nb, nf, rdy);
      chk("w1 busy cycles", nb, 3 + P);
      chk("w1 frame cycles", nf, 1 + P);
      chk("w1 ready after", rdy, 1);

      repeat (3) @(negedge clk);
      chk("u8 queue drained", q8.size(), 0);
      chk("u3 queue drained", q3.size(), 0);
      chk("u1 queue drained", q1.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
